// File: rtl/st_bus_pkg.sv
// Shared types and constants for the 68000-style bus initiator.
// Optional build macro (used by st_bus_sync): ST_BUS_MASTER_SYNC_EN.
package st_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT,
        GAP,
        DONE_ERR
    } state_t;

    // Levels of the active-low bus signals (ACCESS, UDS, LDS, VALID, WTERM).
    localparam logic ASSERT_L = 1'b0;
    localparam logic NEGATE_L = 1'b1;

    // Active-high byte enable to active-low data strobe level.
    function automatic logic strobe_level(input logic enable);
        return enable ? ASSERT_L : NEGATE_L;
    endfunction

endpackage

// File: rtl/st_bus_sync.sv
// Input register for the controller's active-low handshake lines.
// ST_BUS_MASTER_SYNC_EN defined: two-flop synchroniser (controller on an
// unrelated clock). Undefined: a single register stage.
module st_bus_sync
    import st_bus_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q
);

`ifdef ST_BUS_MASTER_SYNC_EN
    logic meta;

    // Two-stage synchroniser; resets to the negated level so nothing looks terminated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= NEGATE_L;
            q    <= NEGATE_L;
        end else begin
            meta <= din;
            q    <= meta;
        end
    end
`else
    // Single register stage; resets to the negated level so nothing looks terminated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= NEGATE_L;
        end else begin
            q <= din;
        end
    end
`endif

endmodule

// File: rtl/st_bus_master.sv
// 68000-style bus initiator: turns one req/ack request into one ordered,
// timed-out ACCESS/UDS/LDS cycle on the SDRAM controller's CPU-side port.
// Optional build macro: ST_BUS_MASTER_SYNC_EN (two-flop VALID/WTERM sync).
module st_bus_master
    import st_bus_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        REQ_WE,
    input  logic [22:0] REQ_ADDR,
    input  logic [1:0]  REQ_BE,
    input  logic [15:0] REQ_WDATA,
    output logic        ACK,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic        BUSY,
    output logic        ACCESS,
    output logic        UDS,
    output logic        LDS,
    output logic        RW,
    output logic [22:0] A,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    input  logic [15:0] D_IN,
    input  logic        VALID,
    input  logic        WTERM
);

    localparam logic [3:0] SETUP_LOAD   = 4'(SETUP_CYC - 1);
    localparam logic [3:0] GAP_LOAD     = 4'(GAP_CYC - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [7:0]  tcnt, tcnt_d;
    logic        we_q, we_d;
    logic [1:0]  be_q, be_d;
    logic        access_d, uds_d, lds_d, rw_d, oe_d, ack_d, err_d;
    logic [22:0] a_d;
    logic [15:0] dout_d, rdata_d;
    logic        vin, wtin;

    st_bus_sync u_valid_sync (.clk(CLK), .rst_n(RST), .din(VALID), .q(vin));
    st_bus_sync u_wterm_sync (.clk(CLK), .rst_n(RST), .din(WTERM), .q(wtin));

    assign BUSY = (state != IDLE);

    // Next-state and next-output logic for the bus cycle sequencer.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_d  = state;
        cnt_d    = cnt;
        tcnt_d   = tcnt;
        we_d     = we_q;
        be_d     = be_q;
        access_d = ACCESS;
        uds_d    = UDS;
        lds_d    = LDS;
        rw_d     = RW;
        a_d      = A;
        dout_d   = D_OUT;
        oe_d     = D_OE;
        rdata_d  = RDATA;
        ack_d    = 1'b0;
        err_d    = 1'b0;

        unique case (state)
            IDLE: begin
                if (REQ) begin
                    if (REQ_BE == 2'b00) begin
                        // Nothing to strobe: report the error without touching the bus.
                        state_d = DONE_ERR;
                    end else begin
                        we_d    = REQ_WE;
                        be_d    = REQ_BE;
                        a_d     = REQ_ADDR;
                        rw_d    = ~REQ_WE;
                        dout_d  = REQ_WDATA;
                        oe_d    = REQ_WE;
                        cnt_d   = SETUP_LOAD;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    // Strobes must fall with ACCESS or the controller aborts a read.
                    access_d = ASSERT_L;
                    uds_d    = strobe_level(be_q[1]);
                    lds_d    = strobe_level(be_q[0]);
                    tcnt_d   = 8'd0;
                    state_d  = WAIT;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            WAIT: begin
                tcnt_d = tcnt + 8'd1;
                // Termination is tested before timeout so it wins a tie.
                if (!we_q && vin == ASSERT_L) begin
                    rdata_d = D_IN;
                    ack_d   = 1'b1;
                end else if (we_q && wtin == ASSERT_L) begin
                    ack_d = 1'b1;
                end else if (tcnt == TIMEOUT_LAST) begin
                    ack_d = 1'b1;
                    err_d = 1'b1;
                end
                if (ack_d) begin
                    access_d = NEGATE_L;
                    uds_d    = NEGATE_L;
                    lds_d    = NEGATE_L;
                    oe_d     = 1'b0;
                    rw_d     = 1'b1;
                    cnt_d    = GAP_LOAD;
                    state_d  = GAP;
                end
            end
            GAP: begin
                // Wait out the minimum gap and for the controller to release both lines.
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else if (vin == NEGATE_L && wtin == NEGATE_L) begin
                    state_d = IDLE;
                end
            end
            DONE_ERR: begin
                ack_d   = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered bus outputs, with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (!RST) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            tcnt   <= 8'd0;
            we_q   <= 1'b0;
            be_q   <= 2'b00;
            ACCESS <= NEGATE_L;
            UDS    <= NEGATE_L;
            LDS    <= NEGATE_L;
            RW     <= 1'b1;
            A      <= '0;
            D_OUT  <= '0;
            D_OE   <= 1'b0;
            RDATA  <= '0;
            ACK    <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            tcnt   <= tcnt_d;
            we_q   <= we_d;
            be_q   <= be_d;
            ACCESS <= access_d;
            UDS    <= uds_d;
            LDS    <= lds_d;
            RW     <= rw_d;
            A      <= a_d;
            D_OUT  <= dout_d;
            D_OE   <= oe_d;
            RDATA  <= rdata_d;
            ACK    <= ack_d;
            ERR    <= err_d;
        end
    end

endmodule

// File: tb/tb_st_bus_master.sv
// Directed bench for st_bus_master with default parameters (1/2/255).
module tb_st_bus_master;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ = 1'b0;
    logic        REQ_WE = 1'b0;
    logic [22:0] REQ_ADDR = '0;
    logic [1:0]  REQ_BE = '0;
    logic [15:0] REQ_WDATA = '0;
    logic        ACK, ERR, BUSY, ACCESS, UDS, LDS, RW, D_OE;
    logic [15:0] RDATA, D_OUT;
    logic [22:0] A;
    logic [15:0] D_IN = '0;
    logic        VALID = 1'b1;
    logic        WTERM = 1'b1;

    int checks = 0;
    int errors = 0;

    st_bus_master dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
        .REQ_BE(REQ_BE), .REQ_WDATA(REQ_WDATA), .ACK(ACK), .ERR(ERR),
        .RDATA(RDATA), .BUSY(BUSY), .ACCESS(ACCESS), .UDS(UDS), .LDS(LDS),
        .RW(RW), .A(A), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
        .VALID(VALID), .WTERM(WTERM)
    );

    always #5 CLK = ~CLK;

    // Advance past the next rising edge; outputs are settled when this returns.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic we, input logic [22:0] addr,
                         input logic [1:0] be, input logic [15:0] wdata);
        REQ_WE    = we;
        REQ_ADDR  = addr;
        REQ_BE    = be;
        REQ_WDATA = wdata;
        REQ       = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (BUSY && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL %s_idle BUSY=%b want 0", name, BUSY); end
    endtask

    task automatic test_reset;
        RST = 1'b0;
        tick();
        tick();
        checks++; if (ACCESS !== 1'b1) begin errors++; $display("FAIL rst_access got %b want 1", ACCESS); end
        checks++; if (UDS !== 1'b1)    begin errors++; $display("FAIL rst_uds got %b want 1", UDS); end
        checks++; if (LDS !== 1'b1)    begin errors++; $display("FAIL rst_lds got %b want 1", LDS); end
        checks++; if (RW !== 1'b1)     begin errors++; $display("FAIL rst_rw got %b want 1", RW); end
        checks++; if (D_OE !== 1'b0)   begin errors++; $display("FAIL rst_doe got %b want 0", D_OE); end
        checks++; if (A !== 23'h0)     begin errors++; $display("FAIL rst_a got %h want 0", A); end
        checks++; if (D_OUT !== 16'h0) begin errors++; $display("FAIL rst_dout got %h want 0", D_OUT); end
        checks++; if (RDATA !== 16'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", RDATA); end
        checks++; if (ACK !== 1'b0 || ERR !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL rst_ack_err_busy got %b%b%b want 000", ACK, ERR, BUSY);
        end
        RST = 1'b1;
        tick();
    endtask

    // Read, BE=11, VALID low 4 cycles after ACCESS falls -> ACK at ACCESS+5.
    task automatic test_read;
        int lat = 0;
        issue(1'b0, 23'h012345, 2'b11, 16'h0);
        tick();
        REQ = 1'b0;
        checks++; if (BUSY !== 1'b1)      begin errors++; $display("FAIL rd_busy got %b want 1", BUSY); end
        checks++; if (A !== 23'h012345)   begin errors++; $display("FAIL rd_addr got %h want 012345", A); end
        checks++; if (RW !== 1'b1 || ACCESS !== 1'b1) begin
            errors++; $display("FAIL rd_setup rw/access got %b%b want 11", RW, ACCESS);
        end
        tick();
        checks++; if ({ACCESS, UDS, LDS} !== 3'b000) begin
            errors++; $display("FAIL rd_strobes got %b want 000", {ACCESS, UDS, LDS});
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ACK) begin lat = i; break; end
            if (i == 3) begin VALID = 1'b0; D_IN = 16'hBEEF; end
        end
        checks++; if (lat != 5)            begin errors++; $display("FAIL rd_latency got %0d want 5", lat); end
        checks++; if (ERR !== 1'b0)        begin errors++; $display("FAIL rd_err got %b want 0", ERR); end
        checks++; if (RDATA !== 16'hBEEF)  begin errors++; $display("FAIL rd_data got %h want beef", RDATA); end
        checks++; if ({ACCESS, UDS, LDS} !== 3'b111) begin
            errors++; $display("FAIL rd_release got %b want 111", {ACCESS, UDS, LDS});
        end
        VALID = 1'b1;
        tick();
        checks++; if (ACK !== 1'b0 || ACCESS !== 1'b1) begin
            errors++; $display("FAIL rd_pulse ack/access got %b%b want 01", ACK, ACCESS);
        end
        tick();
        checks++; if (ACCESS !== 1'b1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL rd_gap access/busy got %b%b want 10", ACCESS, BUSY);
        end
    endtask

    // Write, BE=01, WTERM low 2 cycles after ACCESS falls -> ACK at ACCESS+3.
    task automatic test_write;
        int lat = 0;
        int oe_bad = 0;
        issue(1'b1, 23'h000100, 2'b01, 16'h00A5);
        tick();
        REQ = 1'b0;
        checks++; if (D_OE !== 1'b1 || RW !== 1'b0) begin
            errors++; $display("FAIL wr_setup doe/rw got %b%b want 10", D_OE, RW);
        end
        checks++; if (D_OUT !== 16'h00A5) begin errors++; $display("FAIL wr_dout got %h want 00a5", D_OUT); end
        tick();
        checks++; if ({ACCESS, UDS, LDS} !== 3'b010) begin
            errors++; $display("FAIL wr_strobes got %b want 010", {ACCESS, UDS, LDS});
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ACK) begin lat = i; break; end
            if (D_OE !== 1'b1) oe_bad++;
            if (i == 1) WTERM = 1'b0;
        end
        checks++; if (lat != 3)     begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
        checks++; if (oe_bad != 0)  begin errors++; $display("FAIL wr_doe_hold got %0d drops want 0", oe_bad); end
        checks++; if (ERR !== 1'b0 || D_OE !== 1'b0 || RW !== 1'b1) begin
            errors++; $display("FAIL wr_end err/doe/rw got %b%b%b want 001", ERR, D_OE, RW);
        end
        WTERM = 1'b1;
        wait_idle("wr");
    endtask

    // Read with VALID stuck high -> ERR ACK exactly 255 cycles after ACCESS falls.
    task automatic test_timeout;
        int lat = 0;
        issue(1'b0, 23'h7FFFFF, 2'b10, 16'h0);
        tick();
        REQ = 1'b0;
        tick();
        checks++; if ({ACCESS, UDS, LDS} !== 3'b001) begin
            errors++; $display("FAIL to_strobes got %b want 001", {ACCESS, UDS, LDS});
        end
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (ACK) begin lat = i; break; end
        end
        checks++; if (lat != 255)          begin errors++; $display("FAIL to_latency got %0d want 255", lat); end
        checks++; if (ERR !== 1'b1)        begin errors++; $display("FAIL to_err got %b want 1", ERR); end
        checks++; if (RDATA !== 16'hBEEF)  begin errors++; $display("FAIL to_rdata got %h want beef", RDATA); end
        checks++; if ({ACCESS, UDS, LDS} !== 3'b111) begin
            errors++; $display("FAIL to_release got %b want 111", {ACCESS, UDS, LDS});
        end
        wait_idle("to");
    endtask

    // BE=00 -> error ACK two edges after REQ, no strobe activity.
    task automatic test_be_zero;
        int lat = 0;
        int bus_act = 0;
        issue(1'b1, 23'h000200, 2'b00, 16'hFFFF);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 1) begin
                REQ = 1'b0;
                checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL be0_busy got %b want 1", BUSY); end
            end
            if (!ACCESS || !UDS || !LDS || D_OE) bus_act++;
            if (ACK && lat == 0) begin
                lat = i;
                checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL be0_err got %b want 1", ERR); end
            end
        end
        checks++; if (lat != 2)     begin errors++; $display("FAIL be0_latency got %0d want 2", lat); end
        checks++; if (bus_act != 0) begin errors++; $display("FAIL be0_bus got %0d active cycles want 0", bus_act); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL be0_idle got %b want 0", BUSY); end
    endtask

    // REQ held for three reads; VALID held low 3 cycles into each GAP delays IDLE.
    task automatic test_back_to_back;
        int t = 0, n_ack = 0, n_fall = 0, fall_t = 0, ack_t = 0, hold = 0;
        logic prev_access = 1'b1;
        issue(1'b0, 23'h000010, 2'b11, 16'h0);
        while (t < 200 && !(n_ack == 3 && !BUSY)) begin
            tick();
            t++;
            if (prev_access && !ACCESS) begin
                n_fall++;
                fall_t = t;
                VALID  = 1'b0;
                D_IN   = 16'(16'hC000 + n_fall);
                if (n_fall > 1) begin
                    // 1 gap count + 3 held cycles + sync + IDLE + SETUP.
                    checks++; if (t - ack_t != 7) begin
                        errors++; $display("FAIL b2b_gap got %0d want 7", t - ack_t);
                    end
                end
            end
            prev_access = ACCESS;
            if (ACK) begin
                n_ack++;
                ack_t = t;
                hold  = 3;
                checks++; if (t - fall_t != 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", t - fall_t); end
                checks++; if (RDATA !== 16'(16'hC000 + n_ack) || ERR !== 1'b0) begin
                    errors++; $display("FAIL b2b_data got %h/%b want %h/0", RDATA, ERR, 16'(16'hC000 + n_ack));
                end
                if (n_ack == 3) REQ = 1'b0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) VALID = 1'b1;
            end
        end
        checks++; if (n_ack != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n_ack); end
        VALID = 1'b1;
    endtask

    // Reset in WAIT abandons the cycle; the next request completes normally.
    task automatic test_reset_mid;
        int lat = 0;
        int stray = 0;
        issue(1'b1, 23'h000300, 2'b11, 16'h1234);
        tick();
        REQ = 1'b0;
        repeat (4) tick();
        checks++; if (ACCESS !== 1'b0 || D_OE !== 1'b1) begin
            errors++; $display("FAIL rm_pre access/doe got %b%b want 01", ACCESS, D_OE);
        end
        RST = 1'b0;
        tick();
        checks++; if ({ACCESS, UDS, LDS} !== 3'b111 || D_OE !== 1'b0) begin
            errors++; $display("FAIL rm_bus got %b doe %b want 111 doe 0", {ACCESS, UDS, LDS}, D_OE);
        end
        checks++; if (BUSY !== 1'b0 || ACK !== 1'b0) begin
            errors++; $display("FAIL rm_busy_ack got %b%b want 00", BUSY, ACK);
        end
        checks++; if (A !== 23'h0 || RDATA !== 16'h0) begin
            errors++; $display("FAIL rm_regs got %h/%h want 0/0", A, RDATA);
        end
        RST = 1'b1;
        repeat (6) begin
            tick();
            if (ACK) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rm_stray_ack got %0d want 0", stray); end
        D_IN = 16'h5A5A;
        issue(1'b0, 23'h000400, 2'b11, 16'h0);
        tick();
        REQ = 1'b0;
        tick();
        checks++; if (ACCESS !== 1'b0) begin errors++; $display("FAIL rm_next_access got %b want 0", ACCESS); end
        VALID = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (ACK) begin lat = i; break; end
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL rm_next_latency got %0d want 2", lat); end
        checks++; if (RDATA !== 16'h5A5A || ERR !== 1'b0) begin
            errors++; $display("FAIL rm_next_data got %h/%b want 5a5a/0", RDATA, ERR);
        end
        VALID = 1'b1;
        wait_idle("rm");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_be_zero();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/st_bus_master.md
Name: st_bus_master

Overview:
- 68000-style bus initiator that drives the SDRAM controller's CPU-side interface: ACCESS, UDS, LDS, RW and A[23:1].
- Completes each cycle on VALID (reads) or WTERM (writes).
- Serves on-board masters (memory test/fill engine, DMA helper) through a simple req/ack port, and turns each request into one correctly ordered, timed-out bus cycle.

Parameters:
- SETUP_CYC, 1, cycles A/RW/D_OUT are stable before ACCESS falls (1..15).
- GAP_CYC, 2, minimum cycles ACCESS is held high between cycles (1..15).
- TIMEOUT_CYC, 255, WAIT cycles before abort (8-bit counter, 1..255).

Ports:
- CLK in 1: system clock, same clock as the SDRAM controller.
- RST in 1: synchronous reset, active-low.
- REQ in 1: request level, sampled only in IDLE.
- REQ_WE in 1: 1 = write, 0 = read.
- REQ_ADDR in 23: word address, maps to A[23:1].
- REQ_BE in 2: byte enables, active-high; [1] = upper (UDS), [0] = lower (LDS).
- REQ_WDATA in 16: write data.
- ACK out 1: one-cycle completion pulse.
- ERR out 1: valid with ACK; 1 = timeout or empty BE.
- RDATA out 16: read data, valid from ACK until the next ACK.
- BUSY out 1: high in every state except IDLE.
- ACCESS out 1: active-low cycle qualifier.
- UDS out 1: active-low upper strobe.
- LDS out 1: active-low lower strobe.
- RW out 1: 1 = read.
- A out 23: address.
- D_OUT out 16: write data to bus.
- D_OE out 1: write-data output enable.
- D_IN in 16: read data from bus.
- VALID in 1: active-low read data valid.
- WTERM in 1: active-low write terminate.

Behaviour:
- Reset (RST low at a CLK edge, including mid-cycle):
  - ACCESS = UDS = LDS = RW = 1; D_OE = 0.
  - A = 0, D_OUT = 0, RDATA = 0.
  - ACK = ERR = BUSY = 0; state = IDLE; counters = 0.
  - A pending cycle is abandoned with no ACK.
- VALID and WTERM are registered once (vin/wtin) before use. Both are high while the controller is initialising, so requests wait and time out if init is still in progress.
- States:
  - IDLE: if REQ: latch WE/ADDR/BE/WDATA, drive A, RW = ~WE, D_OUT, D_OE = WE.
    - If BE == 00, go to DONE_ERR with no bus activity.
    - Otherwise go to SETUP with cnt = SETUP_CYC-1.
  - SETUP: count down. At 0: ACCESS = 0, UDS = ~BE[1], LDS = ~BE[0] in the same edge (the controller aborts a read if strobes lag ACCESS). Go to WAIT with tcnt = 0.
  - WAIT: tcnt++.
    - Read and vin == 0: RDATA <= D_IN, ACK = 1, ERR = 0.
    - Write and wtin == 0: ACK = 1, ERR = 0.
    - tcnt == TIMEOUT_CYC-1 with no termination: ACK = 1, ERR = 1, RDATA unchanged.
    - All three exits drive ACCESS = UDS = LDS = 1 and D_OE = 0 on the same edge, then go to GAP with cnt = GAP_CYC-1.
  - DONE_ERR: ACK = 1, ERR = 1 for one cycle, go to IDLE. No GAP, since ACCESS never fell.
  - GAP: ACCESS high. Leave to IDLE when cnt == 0 and vin == 1 and wtin == 1; otherwise hold. RW returns to 1 on entry.
- ACK is a single-cycle pulse and is never asserted outside WAIT exit or DONE_ERR.
- Back-to-back: if REQ is still high in IDLE after GAP, a new cycle starts. The requester drops REQ on the ACK cycle for single transfers.
- Simultaneous termination and timeout in the same cycle: termination wins (ERR = 0).
- Latency, read, SETUP_CYC = 1, controller VALID low N cycles after ACCESS falls:
  - ACCESS falls 2 edges after REQ is sampled.
  - ACK occurs N+1 cycles after ACCESS falls.
- Width rules:
  - tcnt is 8 bits and never wraps (it exits at TIMEOUT_CYC-1).
  - cnt is 4 bits.

Optional Feature:
- ST_BUS_MASTER_SYNC_EN defined: VALID and WTERM pass through a 2-flop synchroniser instead of one register. This adds 1 cycle to completion latency and to the GAP exit condition, for use when the controller runs on an unrelated clock.
- Undefined: single register as above.

Decomposition:
- Package st_bus_pkg holds:
  - the state enum (IDLE, SETUP, WAIT, GAP, DONE_ERR);
  - active-low level constants ASSERT_L = 0, NEGATE_L = 1.
- Sub-module st_bus_sync: 1- or 2-stage input register selected by the macro, instanced for VALID and WTERM.

Test Plan:
- Read, BE = 11, ADDR = 0x012345; controller model drives VALID low 4 cycles after ACCESS falls with D_IN = 0xBEEF -> UDS/LDS low with ACCESS, ACK at ACCESS+5, RDATA = 0xBEEF, ERR = 0, ACCESS high ≥ 2 cycles after.
- Write, BE = 01, WDATA = 0x00A5; WTERM low 2 cycles after ACCESS falls -> UDS = 1, LDS = 0, D_OE = 1 from SETUP until ACK, ACK at ACCESS+3, ERR = 0.
- Read with VALID held high (controller in init) -> ACK with ERR = 1 exactly TIMEOUT_CYC = 255 cycles after ACCESS falls, RDATA retains its previous value, ACCESS released.
- REQ_BE = 00 -> ACK and ERR = 1 two edges after REQ; ACCESS/UDS/LDS never go low.
- REQ held high for 3 reads -> three ACKs, ACCESS high ≥ GAP_CYC cycles between each; VALID held low during GAP -> IDLE is delayed until VALID goes high.
- RST low mid-WAIT -> next edge ACCESS = UDS = LDS = 1, D_OE = 0, BUSY = 0, no ACK; the next REQ after reset completes normally.
